// File: rtl/cpu_io_port_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_port_if
// Description : Signal bundle for cpu_io_port. Groups the CPU OUT/IN strobes
//               and data with the external TX/RX valid/ready handshakes.
//               slave  - seen by the port itself
//               master - seen by the CPU/external environment
// Signals     : cpu_out_wr, cpu_out_data[7:0], cpu_in_rd, cpu_in_data[31:0],
//               ext_tx_valid, ext_tx_data[7:0], ext_tx_ready,
//               ext_rx_valid, ext_rx_data[7:0], ext_rx_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_io_port_if;
  logic        cpu_out_wr;
  logic [7:0]  cpu_out_data;
  logic        cpu_in_rd;
  logic [31:0] cpu_in_data;
  logic        ext_tx_valid;
  logic [7:0]  ext_tx_data;
  logic        ext_tx_ready;
  logic        ext_rx_valid;
  logic [7:0]  ext_rx_data;
  logic        ext_rx_ready;

  modport slave (
    input  cpu_out_wr, cpu_out_data, cpu_in_rd,
    input  ext_tx_ready, ext_rx_valid, ext_rx_data,
    output cpu_in_data, ext_tx_valid, ext_tx_data, ext_rx_ready
  );

  modport master (
    output cpu_out_wr, cpu_out_data, cpu_in_rd,
    output ext_tx_ready, ext_rx_valid, ext_rx_data,
    input  cpu_in_data, ext_tx_valid, ext_tx_data, ext_rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/cpu_io_port.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_port
// Description : Byte-wide CPU I/O port. CPU OUT bytes queue in a TX FIFO for
//               an external consumer; external bytes queue in an RX FIFO for
//               CPU IN reads. Each read returns {16'h0, status, byte}.
//               Optional macro CPU_IO_PORT_LOOPBACK_EN adds a 'loopback'
//               input that routes TX head into RX internally.
// Ports       : clk, rst (async, active-high)
//               bus (cpu_io_port_if.slave) - CPU strobes/data, ext handshakes
//               loopback (only with CPU_IO_PORT_LOOPBACK_EN)
// Status byte : [0] rx_avail [1] tx_full [2] tx_empty [3] tx_ovf [4] rx_udf
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_io_port #(
  parameter int DEPTH_LOG2 = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
`ifdef CPU_IO_PORT_LOOPBACK_EN
  input  wire logic         loopback,
`endif
  cpu_io_port_if.slave      bus
);

  localparam int                    c_DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_FULL    = (DEPTH_LOG2+1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

  // TX FIFO state
  logic [7:0]            r_tx_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp;
  logic [DEPTH_LOG2:0]   r_tx_cnt;
  logic                  r_tx_ovf;

  // RX FIFO state
  logic [7:0]            r_rx_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_rx_wp, r_rx_rp;
  logic [DEPTH_LOG2:0]   r_rx_cnt;
  logic                  r_rx_udf;

  logic [31:0]           r_in_data;

  logic                  w_tx_nempty, w_tx_full, w_rx_nempty, w_rx_full;
  logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic                  w_tx_ovf_set, w_rx_udf_set;
  logic [7:0]            w_rx_wdata, w_rx_byte, w_status;
  logic [DEPTH_LOG2:0]   w_tx_cnt_nxt, w_rx_cnt_nxt;

  assign w_tx_nempty = (r_tx_cnt != '0);
  assign w_tx_full   = (r_tx_cnt == c_FULL);
  assign w_rx_nempty = (r_rx_cnt != '0);
  assign w_rx_full   = (r_rx_cnt == c_FULL);

  // Outputs depend only on registered state; memories reset to zero so the
  // head reads 8'h00 out of reset.
  assign bus.ext_tx_data = r_tx_mem[r_tx_rp];

`ifdef CPU_IO_PORT_LOOPBACK_EN
  logic w_lb_xfer;
  assign bus.ext_tx_valid = w_tx_nempty & ~loopback;
  assign bus.ext_rx_ready = ~w_rx_full & ~loopback;
  assign w_lb_xfer        = loopback & w_tx_nempty & ~w_rx_full;
  assign w_tx_pop         = w_lb_xfer | (bus.ext_tx_valid & bus.ext_tx_ready);
  assign w_rx_push        = w_lb_xfer | (bus.ext_rx_valid & bus.ext_rx_ready);
  assign w_rx_wdata       = loopback ? r_tx_mem[r_tx_rp] : bus.ext_rx_data;
`else
  assign bus.ext_tx_valid = w_tx_nempty;
  assign bus.ext_rx_ready = ~w_rx_full;
  assign w_tx_pop         = bus.ext_tx_valid & bus.ext_tx_ready;
  assign w_rx_push        = bus.ext_rx_valid & bus.ext_rx_ready;
  assign w_rx_wdata       = bus.ext_rx_data;
`endif

  // A write into a full FIFO is accepted only if the head leaves this cycle.
  assign w_tx_push    = bus.cpu_out_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set = bus.cpu_out_wr & w_tx_full & ~w_tx_pop;

  // A read of an empty RX underflows even if a byte arrives this cycle.
  assign w_rx_pop     = bus.cpu_in_rd & w_rx_nempty;
  assign w_rx_udf_set = bus.cpu_in_rd & ~w_rx_nempty;
  assign w_rx_byte    = w_rx_pop ? r_rx_mem[r_rx_rp] : 8'h00;

  always_comb begin
    w_tx_cnt_nxt = r_tx_cnt;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_cnt_nxt = r_tx_cnt + c_CNT_ONE;
      2'b01:   w_tx_cnt_nxt = r_tx_cnt - c_CNT_ONE;
      default: w_tx_cnt_nxt = r_tx_cnt;
    endcase
  end

  always_comb begin
    w_rx_cnt_nxt = r_rx_cnt;
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_cnt_nxt = r_rx_cnt + c_CNT_ONE;
      2'b01:   w_rx_cnt_nxt = r_rx_cnt - c_CNT_ONE;
      default: w_rx_cnt_nxt = r_rx_cnt;
    endcase
  end

  // Status reflects occupancy and sticky bits after this cycle's updates.
  assign w_status = {3'b000,
                     r_rx_udf | w_rx_udf_set,
                     r_tx_ovf | w_tx_ovf_set,
                     (w_tx_cnt_nxt == '0),
                     (w_tx_cnt_nxt == c_FULL),
                     (w_rx_cnt_nxt != '0)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_tx_mem[i] <= 8'h00;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wp] <= bus.cpu_out_data;
        r_tx_wp           <= r_tx_wp + c_PTR_ONE;
      end
      if (w_tx_pop) r_tx_rp <= r_tx_rp + c_PTR_ONE;
      r_tx_cnt <= w_tx_cnt_nxt;
      r_tx_ovf <= r_tx_ovf | w_tx_ovf_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_rx_mem[i] <= 8'h00;
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_rx_udf  <= 1'b0;
      r_in_data <= 32'h0000_0000;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wp] <= w_rx_wdata;
        r_rx_wp           <= r_rx_wp + c_PTR_ONE;
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + c_PTR_ONE;
      r_rx_cnt <= w_rx_cnt_nxt;
      r_rx_udf <= r_rx_udf | w_rx_udf_set;
      if (bus.cpu_in_rd) r_in_data <= {16'h0000, w_status, w_rx_byte};
    end
  end

  assign bus.cpu_in_data = r_in_data;

endmodule
`default_nettype wire

// File: tb/tb_cpu_io_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_io_port
// Description : Directed self-checking bench for cpu_io_port. Inputs change
//               1 time unit after a rising edge; outputs are sampled there.
//               Loopback scenario is built when CPU_IO_PORT_LOOPBACK_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_io_port;

  logic clk;
  logic rst;
`ifdef CPU_IO_PORT_LOOPBACK_EN
  logic loopback;
`endif

  int n_total;
  int n_bad;

  cpu_io_port_if bus ();

  cpu_io_port #(.DEPTH_LOG2(2)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef CPU_IO_PORT_LOOPBACK_EN
    .loopback (loopback),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_out_wr   = 1'b0;
    bus.cpu_out_data = 8'h00;
    bus.cpu_in_rd    = 1'b0;
    bus.ext_tx_ready = 1'b0;
    bus.ext_rx_valid = 1'b0;
    bus.ext_rx_data  = 8'h00;
`ifdef CPU_IO_PORT_LOOPBACK_EN
    loopback = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One-cycle CPU read; result visible after the edge.
  task automatic cpu_read();
    bus.cpu_in_rd = 1'b1;
    step();
    bus.cpu_in_rd = 1'b0;
  endtask

  logic [7:0] tx_bytes [4];
  logic [7:0] exp_drain [4];

  initial begin
    n_total = 0;
    n_bad   = 0;
    idle_inputs();
    rst = 1'b1;
    #2;
    // ---------------- reset values ----------------
    check_val("rst_in_data",  bus.cpu_in_data,          32'h0000_0000);
    check_val("rst_tx_valid", {31'd0, bus.ext_tx_valid}, 32'd0);
    check_val("rst_tx_data",  {24'd0, bus.ext_tx_data},  32'd0);
    check_val("rst_rx_ready", {31'd0, bus.ext_rx_ready}, 32'd1);
    step();
    rst = 1'b0;

    // ---------------- underflow read ----------------
    cpu_read();
    check_val("udf_read", bus.cpu_in_data, 32'h0000_1400);

    // ---------------- TX fill / overflow / drain ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.cpu_out_wr   = 1'b1;
      bus.cpu_out_data = 8'hA1 + 8'(i);
      step();
    end
    bus.cpu_out_wr = 1'b0;
    check_val("tx_valid_full", {31'd0, bus.ext_tx_valid}, 32'd1);
    cpu_read();
    // tx_full | tx_ovf | rx_udf
    check_val("tx_ovf_status", bus.cpu_in_data, 32'h0000_1A00);
    bus.ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("tx_drain_data",  {24'd0, bus.ext_tx_data}, {24'd0, 8'hA1 + 8'(i)});
      check_val("tx_drain_valid", {31'd0, bus.ext_tx_valid}, 32'd1);
      step();
    end
    check_val("tx_drained_valid", {31'd0, bus.ext_tx_valid}, 32'd0);
    bus.ext_tx_ready = 1'b0;

    // ---------------- RX fill / backpressure / reads ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check_val("rx_ready_open", {31'd0, bus.ext_rx_ready}, 32'd1);
      bus.ext_rx_valid = 1'b1;
      bus.ext_rx_data  = 8'h10 + 8'(i);
      step();
    end
    bus.ext_rx_valid = 1'b0;
    check_val("rx_ready_full", {31'd0, bus.ext_rx_ready}, 32'd0);
    cpu_read();
    check_val("rx_read0", bus.cpu_in_data, 32'h0000_0510);
    cpu_read();
    check_val("rx_read1", bus.cpu_in_data, 32'h0000_0511);
    cpu_read();
    check_val("rx_read2", bus.cpu_in_data, 32'h0000_0512);
    cpu_read();
    check_val("rx_read3", bus.cpu_in_data, 32'h0000_0413);
    check_val("rx_ready_again", {31'd0, bus.ext_rx_ready}, 32'd1);

    // ---------------- TX full with simultaneous push/pop ----------------
    do_reset();
    tx_bytes[0] = 8'hB0; tx_bytes[1] = 8'hB1;
    tx_bytes[2] = 8'hB2; tx_bytes[3] = 8'hB3;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_out_wr   = 1'b1;
      bus.cpu_out_data = tx_bytes[i];
      step();
    end
    bus.cpu_out_data = 8'h55;
    bus.ext_tx_ready = 1'b1;
    step();
    bus.cpu_out_wr   = 1'b0;
    bus.ext_tx_ready = 1'b0;
    cpu_read();
    // still full, no tx_ovf, only rx_udf
    check_val("pushpop_status", bus.cpu_in_data, 32'h0000_1200);
    exp_drain[0] = 8'hB1; exp_drain[1] = 8'hB2;
    exp_drain[2] = 8'hB3; exp_drain[3] = 8'h55;
    bus.ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("pushpop_drain", {24'd0, bus.ext_tx_data}, {24'd0, exp_drain[i]});
      step();
    end
    check_val("pushpop_empty", {31'd0, bus.ext_tx_valid}, 32'd0);
    bus.ext_tx_ready = 1'b0;

    // ---------------- pointer wrap: 20 bytes, reads interleaved ----------------
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.ext_rx_valid = 1'b1;
      bus.ext_rx_data  = 8'(i);
      bus.cpu_in_rd    = (i > 0);
      step();
      if (i > 0)
        check_val("wrap_read", bus.cpu_in_data, 32'h0000_0500 | 32'(i - 1));
    end
    bus.ext_rx_valid = 1'b0;
    cpu_read();
    check_val("wrap_last", bus.cpu_in_data, 32'h0000_0413);

`ifdef CPU_IO_PORT_LOOPBACK_EN
    // ---------------- loopback ----------------
    begin
      logic saw_valid;
      do_reset();
      saw_valid = 1'b0;
      loopback  = 1'b1;
      check_val("lb_rx_ready", {31'd0, bus.ext_rx_ready}, 32'd0);
      bus.cpu_out_wr   = 1'b1;
      bus.cpu_out_data = 8'h3C;
      step();
      bus.cpu_out_wr = 1'b0;
      saw_valid = saw_valid | bus.ext_tx_valid;
      step();
      saw_valid = saw_valid | bus.ext_tx_valid;
      step();
      saw_valid = saw_valid | bus.ext_tx_valid;
      cpu_read();
      saw_valid = saw_valid | bus.ext_tx_valid;
      check_val("lb_read", bus.cpu_in_data, 32'h0000_043C);
      check_val("lb_tx_valid_low", {31'd0, saw_valid}, 32'd0);
      loopback = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
